// File: rtl/mult_datapath.sv
// Datapath of the sequential shift-add multiplier: operand/product registers, iteration counter, result capture.
// Build option MULT_OVF_EN registers the "product exceeds WIDTH bits" flag; without it ovf is tied low.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               shift_load,
  input  logic               l_lsb,
  input  logic               finish_cycle,
  input  logic               lsb_sel,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               i_eq_0,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     s_q, s_d;
  logic               lsb_q, lsb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] p_shift;
  logic               shift_en;
  logic               capture;

  assign i_eq_0   = (cnt_q == '0);
  assign shift_en = ~init & lsb_sel & shift_load;
  assign capture  = shift_en & i_eq_0;

  // The sampled lsb chooses between the carry-extended partial sum and a plain shift.
  assign p_shift = lsb_q ? {s_q, p_q[WIDTH-1:1]}
                         : {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};

  always_comb begin
    m_d      = m_q;
    p_d      = p_q;
    s_d      = s_q;
    lsb_d    = lsb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (init) begin
      m_d   = multiplicand;
      p_d   = {{WIDTH{1'b0}}, multiplier};
      s_d   = '0;
      lsb_d = 1'b0;
      cnt_d = CW'(WIDTH);
    end else begin
      if (l_lsb) begin
        lsb_d = p_q[0];
        s_d   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
      end
      // Counter saturates at zero so a stray decrement never re-arms the loop.
      if (finish_cycle && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
      if (shift_en)
        p_d = p_shift;
      if (capture) begin
        result_d = p_shift;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q      <= '0;
      p_q      <= '0;
      s_q      <= '0;
      lsb_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      m_q      <= m_d;
      p_q      <= p_d;
      s_q      <= s_d;
      lsb_q    <= lsb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

`ifdef MULT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (capture)
      ovf_d = |p_shift[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else
      ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: acts as the control unit and checks products through an expected-result queue.
module tb_mult_datapath;

  localparam int W = 32;
  localparam int LAST = 3 * W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           init = 1'b0;
  logic           shift_load = 1'b0;
  logic           l_lsb = 1'b0;
  logic           finish_cycle = 1'b0;
  logic           lsb_sel = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           i_eq_0;
  logic [2*W-1:0] result;
  logic           done;
  logic           ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] sb[$];

  mult_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .init(init), .shift_load(shift_load), .l_lsb(l_lsb),
    .finish_cycle(finish_cycle), .lsb_sel(lsb_sel), .multiplicand(multiplicand),
    .multiplier(multiplier), .i_eq_0(i_eq_0), .result(result), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ovf(input logic [2*W-1:0] p);
`ifdef MULT_OVF_EN
    return |p[2*W-1:W];
`else
    return 1'b0;
`endif
  endfunction

  // Drives one product from its init cycle (cycle 0) up to but excluding stop_at.
  // A full run uses stop_at = LAST+1; shorter runs abort and drop their queued product.
  task automatic run_product(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int stop_at, input int chg_at);
    logic [2*W-1:0] exp_v;
    logic [2*W-1:0] got;
    logic           exp_z;
    exp_v = {{W{1'b0}}, a};
    exp_v = exp_v * {{W{1'b0}}, b};
    sb.push_back(exp_v);
    for (int c = 0; c < stop_at; c++) begin
      init = (c == 0);
      l_lsb = 1'b0; finish_cycle = 1'b0; lsb_sel = 1'b0; shift_load = 1'b0;
      if (c == 0) begin
        multiplicand = a;
        multiplier   = b;
      end
      if (c >= 1 && c <= 3 * W) begin
        case ((c - 1) % 3)
          0: begin l_lsb = 1'b1; finish_cycle = 1'b1; end
          2: begin lsb_sel = 1'b1; shift_load = 1'b1; end
          default: ;
        endcase
      end
      if (c == chg_at) begin
        multiplicand = 9;
        multiplier   = 9;
      end
      @(negedge clk);
      if (c >= 1) begin
        exp_z = (c >= 3 * W - 1);
        n_cmp++;
        if (i_eq_0 !== exp_z) begin
          n_bad++;
          $display("FAIL i_eq_0 cycle %0d: got %b want %b", c, i_eq_0, exp_z);
        end
        n_cmp++;
        if (done !== (c == LAST)) begin
          n_bad++;
          $display("FAIL done_timing cycle %0d: got %b want %b", c, done, (c == LAST));
        end
        if (done === 1'b1 && sb.size() != 0) begin
          got = sb.pop_front();
          n_cmp++;
          if (result !== got) begin
            n_bad++;
            $display("FAIL result: got %h want %h", result, got);
          end
          n_cmp++;
          if (ovf !== exp_ovf(got)) begin
            n_bad++;
            $display("FAIL ovf: got %b want %b", ovf, exp_ovf(got));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    init = 1'b0; l_lsb = 1'b0; finish_cycle = 1'b0; lsb_sel = 1'b0; shift_load = 1'b0;
    if (stop_at <= LAST && sb.size() != 0)
      void'(sb.pop_back());
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL missing_done: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if (result !== '0 || done !== 1'b0 || ovf !== 1'b0 || i_eq_0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got r=%h d=%b o=%b z=%b want 0/0/0/1", result, done, ovf, i_eq_0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    run_product(6, 7, LAST + 1, -1);
  endtask

  task automatic test_max;
    run_product('1, '1, LAST + 1, -1);
    n_cmp++;
    if (result !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++;
      $display("FAIL max_product: got %h want %h", result, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_zero;
    run_product(32'h1234_5678, 0, LAST + 1, -1);
    run_product(0, 32'hDEAD_BEEF, LAST + 1, -1);
  endtask

  task automatic test_operand_change;
    run_product(3, 5, LAST + 1, 10);
    n_cmp++;
    if (result !== 64'd15) begin
      n_bad++;
      $display("FAIL operand_change: got %0d want 15", result);
    end
  endtask

  task automatic test_shift_load_alone;
    shift_load = 1'b1;
    @(posedge clk);
    #1;
    shift_load = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (result !== 64'd15 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL shift_load_alone: got r=%0d d=%b want 15/0", result, done);
    end
  endtask

  task automatic test_async_reset;
    run_product(6, 7, LAST + 1, -1);
    run_product(200, 300, 40, -1);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (result !== '0 || done !== 1'b0 || ovf !== 1'b0 || i_eq_0 !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got r=%h d=%b o=%b z=%b want 0/0/0/1", result, done, ovf, i_eq_0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_product(2, 3, LAST + 1, -1);
    n_cmp++;
    if (result !== 64'd6) begin
      n_bad++;
      $display("FAIL reinit_after_reset: got %0d want 6", result);
    end
  endtask

  task automatic test_back_to_back;
    run_product(11, 13, 50, -1);
    n_cmp++;
    if (result !== 64'd6) begin
      n_bad++;
      $display("FAIL abort_keeps_result: got %0d want 6", result);
    end
    run_product(10, 10, LAST + 1, -1);
    n_cmp++;
    if (result !== 64'd100) begin
      n_bad++;
      $display("FAIL back_to_back: got %0d want 100", result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_operand_change();
    test_shift_load_alone();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Datapath for the sequential shift-add multiplier, driven cycle by cycle by the multiplier control unit. Each iteration takes three cycles:
- a sample/add cycle;
- an idle cycle;
- a shift cycle.

The block accepts the control unit's strobes (`init`, `l_lsb`, `finish_cycle`, `lsb_sel`, `shift_load`) and returns the loop-termination flag `i_eq_0`. It captures the finished 2·WIDTH-bit product into a result register with a `done` pulse for downstream consumers.

## Interface
- WIDTH, 32, operand width in bits; ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  load operands and restart the loop; highest priority.
- shift_load  in  1  register write enable for the product path.
- l_lsb  in  1  sample P[0] and compute the partial sum.
- finish_cycle  in  1  decrement the iteration counter.
- lsb_sel  in  1  shift step; choose the sum path or the plain path by the sampled lsb.
- multiplicand  in  WIDTH  operand A; sampled only on an init cycle.
- multiplier  in  WIDTH  operand B; sampled only on an init cycle.
- i_eq_0  out  1  combinational: iteration counter == 0.
- result  out  2·WIDTH  last completed product, registered.
- done  out  1  one-cycle pulse, the cycle after `result` updates.
- ovf  out  1  registered: result[2W-1:W] != 0 (see Configuration).

## Operation
Registers:
- M[W-1:0]: multiplicand.
- P[2W-1:0]: high half PH, low half PL.
- S[W:0]: carry plus sum.
- lsb_q: sampled multiplier bit.
- cnt: width $clog2(WIDTH+1).
- result, done, ovf.

Actions per rising edge, by priority:
- init=1 (any other inputs):
  - M ← multiplicand, PH ← 0, PL ← multiplier, cnt ← WIDTH, S ← 0, lsb_q ← 0.
  - result and ovf are untouched.
- l_lsb=1:
  - lsb_q ← P[0].
  - S ← {1'b0,PH} + {1'b0,(P[0] ? M : 0)}, full W+1-bit add with carry kept.
- finish_cycle=1 and cnt≠0: cnt ← cnt−1.
  - At cnt=0 the counter holds; no wrap to all-ones.
- lsb_sel=1 and shift_load=1:
  - lsb_q=1: P ← {S, PL[W-1:1]}.
  - lsb_q=0: P ← {1'b0, PH, PL[W-1:1]}.
- lsb_sel=1 and shift_load=0: no P update.
- Final capture: if lsb_sel=1, shift_load=1 and i_eq_0=1 in the same cycle, then result ← the new P value and done ← 1 on that edge. Otherwise done ← 0.
- No strobes asserted (idle cycle): all registers hold.
- shift_load alone, without init or lsb_sel: no effect.

`l_lsb` and `finish_cycle` arrive together in the control unit's sample cycle, and both actions apply on that edge.

Arithmetic rules:
- Unsigned only.
- The product of two W-bit values is exact in 2W bits.

## Timing
Reset:
- All registers 0, so i_eq_0=1, result=0, done=0, ovf=0.
- Reset is asserted asynchronously and takes effect mid-operation; no partial result is ever captured.

Latency (cycle 0 = init cycle):
- Iteration k (0..W-1) occupies cycles 3k+1 (sample), 3k+2 (idle) and 3k+3 (shift).
- cnt reaches 0 at the end of cycle 3W-2, so i_eq_0=1 during the final shift cycle 3W.
- result is valid from cycle 3W+1, and done=1 in cycle 3W+1 only. For W=32: result updates at the end of cycle 96, done is high in cycle 97.

Boundary conditions:
- Operands are sampled only at init. Input changes mid-loop have no effect.
- An init arriving mid-loop aborts the current product: no capture, result keeps its old value.
- result holds until the next final capture. Back-to-back products overwrite it.

## Configuration
- MULT_OVF_EN defined:
  - ovf is a real register, loaded with |P_new[2W-1:W] on the final capture edge and cleared by reset.
  - ovf means "product does not fit in WIDTH bits".
- MULT_OVF_EN undefined: the ovf port exists but is tied to 0, with no register.

## Test plan
- Reset, then init with A=6, B=7 (W=32) → i_eq_0=1 from reset; result=42 after cycle 96; done high only in cycle 97; ovf=0.
- A=0xFFFFFFFF, B=0xFFFFFFFF → result=0xFFFFFFFE00000001. With MULT_OVF_EN, ovf=1; without it, ovf=0.
- A=0x12345678, B=0 and A=0, B=0xDEADBEEF → result=0 both times, done pulses each time, i_eq_0 high exactly in the final shift cycles.
- Start A=3, B=5, then change the operand inputs to 9 and 9 in cycle 10 → result=15.
- Assert rst at cycle 40 of a product (previous result 42) → result=0, done=0, cnt=0 immediately. A re-init with A=2, B=3 → result=6 at cycle 97.
- Re-init at cycle 50 with A=10, B=10 → no capture from the aborted product; result=100 at 97 cycles after the second init.
